serial_parity_checker: RTL and testbench
========================================

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_W, default 4, data bits per frame (range 1..32).
REQ-002 Parameter ODD, default 0, parity mode: 0 = even, 1 = odd.
REQ-003 Parameter CNT_W, default 8, width of the error counter (range 1..16).
REQ-004 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port bit_valid  input  1  bit_in carries a serial bit this cycle.
REQ-007 Port bit_in  input  1  serial data/parity bit.
REQ-008 Port in_ready  output  1  block accepts a serial bit this cycle.
REQ-009 Port out_valid  output  1  a completed frame is presented.
REQ-010 Port out_ready  input  1  consumer accepts the presented frame.
REQ-011 Port out_data  output  DATA_W  received data word.
REQ-012 Port out_err  output  1  parity error flag for the presented frame.
REQ-013 Port err_count  output  CNT_W  saturating count of errored frames.
REQ-014 Port clr_count  input  1  synchronous clear of err_count.

Function
REQ-015 A bit shall be accepted only in a cycle where bit_valid=1 and in_ready=1; bit_in shall be ignored in all other cycles.
REQ-016 A frame shall be DATA_W data bits, LSB first, followed by one parity bit.
REQ-017 The k-th accepted data bit (k = 0..DATA_W-1) shall be stored in out_data[k].
REQ-018 The FSM shall have two states.
- COLLECT: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-019 In COLLECT, a bit index counter shall run 0..DATA_W and increment on each accepted bit.
REQ-020 Acceptance of the parity bit (index DATA_W) shall move the FSM to HOLD on the next edge and zero the index.
REQ-021 out_valid shall rise in the cycle immediately after the parity bit is accepted, giving a latency of 1 cycle.
REQ-022 out_err shall be computed as follows.
- Even mode (ODD=0): out_err = XOR of the DATA_W data bits and the parity bit.
- Odd mode (ODD=1): out_err = inverse of that XOR.
REQ-023 Parity shall be accumulated incrementally as bits are accepted; no recomputation over the full word shall be required.
REQ-024 In HOLD, out_data and out_err shall remain stable until out_valid=1 and out_ready=1.
REQ-025 On that handshake, the FSM shall return to COLLECT on the next edge.
REQ-026 A bit presented in the handshake cycle shall not be accepted, because in_ready=0 in that cycle.
REQ-027 In COLLECT, out_data shall hold the last completed frame.
REQ-028 In COLLECT, out_err shall be 0.
REQ-029 err_count shall increment by 1 on the edge where the FSM enters HOLD with out_err=1.
REQ-030 err_count shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-031 When clr_count=1, err_count shall become 0 on the next edge; clear shall win over a simultaneous increment.
REQ-032 Frames with no error shall not change err_count.

Reset
REQ-033 When rst=1 at a clock edge, the following shall hold on the next cycle.
- FSM in COLLECT, bit index 0, parity accumulator cleared.
- in_ready=1, out_valid=0, out_err=0.
- out_data all zeros, err_count 0.
REQ-034 Reset mid-frame shall discard all partially received bits; the next accepted bit after reset shall be data bit 0.
REQ-035 Reset in HOLD shall drop the presented frame without a handshake.
REQ-036 rst shall take priority over clr_count, bit_valid and out_ready.

Structure
REQ-037 A shared package parity_pkg shall contain the following.
- The FSM state enum (COLLECT, HOLD).
- Localparams PAR_EVEN=0 and PAR_ODD=1.
REQ-038 The saturating error counter shall be a sub-module named sat_counter, parameterised by width, with synchronous clear and increment inputs.

Verification
REQ-039 The bench shall run the following directed scenarios with DATA_W=4.
- Clean even frame: ODD=0, bits 1,0,1,1 then parity 1 -> out_valid=1 one cycle after the parity bit, out_data=4'b1101, out_err=0, err_count=0.
- Errored even frame: same data, parity 0 -> out_err=1, err_count=1.
- Odd mode: ODD=1, data bits 1,0,1,1 then parity 0 -> out_err=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD with bit_valid=1 throughout -> in_ready=0, out_data and out_err unchanged, no bits absorbed; the next frame starts after the handshake.
- Saturation and clear: CNT_W=2, 4 errored frames -> err_count=3; clr_count asserted in the cycle of a 5th errored frame's entry to HOLD -> err_count=0.
- Reset mid-frame: rst after 2 accepted bits, then bits 0,1,1,0 and parity 0 (even) -> out_data=4'b0110, out_err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM state type and parity-mode constants
package parity_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Error flag for a finished frame: running data parity, the received
    // parity bit, and the mode's expected polarity.
    function automatic logic frame_parity_err(input logic acc, input logic par_bit, input logic odd_mode);
        return acc ^ par_bit ^ odd_mode;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    // Clear beats increment; increments stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - LSB-first serial frame receiver with parity check and error count
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr_count
);

    localparam int               IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);
    localparam logic             ODD_BIT  = (ODD == PAR_ODD);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              par_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_err_q;
    logic              accept;
    logic              last_bit;
    logic              frame_done;
    logic              frame_err;
    logic              handshake;

    assign accept     = bit_valid & in_ready;
    assign last_bit   = (idx_q == LAST_IDX);
    assign frame_done = accept & last_bit;
    assign frame_err  = frame_parity_err(par_q, bit_in, ODD_BIT);
    assign handshake  = out_valid & out_ready;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs: collect until the parity bit lands, then hold until taken.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (bit_valid && last_bit) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Datapath: place data bits by index, fold parity as bits arrive, publish the frame on the parity bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            par_q      <= 1'b0;
            data_q     <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (last_bit) begin
                    out_data_q <= data_q;
                    out_err_q  <= frame_err;
                    idx_q      <= '0;
                    par_q      <= 1'b0;
                end else begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            data_q[i] <= bit_in;
                        end
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    par_q <= par_q ^ bit_in;
                end
            end
            if (handshake) begin
                out_err_q <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_count),
        .inc  (frame_done & frame_err),
        .count(err_count)
    );

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - directed and randomized bench for serial_parity_checker
module tb_serial_parity_checker;

    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_count = 1'b0;

    logic       e_in_ready, e_out_valid, e_out_err;
    logic [3:0] e_out_data;
    logic [1:0] e_err_count;
    logic       o_in_ready, o_out_valid, o_out_err;
    logic [3:0] o_out_data;
    logic [7:0] o_err_count;

    serial_parity_checker #(.DATA_W(DW), .ODD(0), .CNT_W(2)) dut_even (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .in_ready(e_in_ready), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_data(e_out_data), .out_err(e_out_err), .err_count(e_err_count),
        .clr_count(clr_count)
    );

    serial_parity_checker #(.DATA_W(DW), .ODD(1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .in_ready(o_in_ready), .out_valid(o_out_valid), .out_ready(out_ready),
        .out_data(o_out_data), .out_err(o_out_err), .err_count(o_err_count),
        .clr_count(clr_count)
    );

    int         tests = 0;
    int         fails = 0;
    bit         chk_en = 1'b0;

    bit         m_hold;
    int         m_bits;
    logic [3:0] m_acc;
    logic [3:0] m_data;
    bit         m_err_even;
    int         m_cnt_e;
    int         m_cnt_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare all outputs with the model, advance the model, cross the edge.
    task automatic cycle(input logic v, input logic b, input logic r, input logic c, input logic rs);
        bit inc_e;
        bit inc_o;
        bit_valid = v;
        bit_in    = b;
        out_ready = r;
        clr_count = c;
        rst       = rs;
        if (chk_en) begin
            check("e_in_ready",  e_in_ready,  !m_hold);
            check("e_out_valid", e_out_valid, m_hold);
            check("e_out_data",  e_out_data,  m_data);
            check("e_out_err",   e_out_err,   m_hold && m_err_even);
            check("e_err_count", e_err_count, m_cnt_e);
            check("o_in_ready",  o_in_ready,  !m_hold);
            check("o_out_valid", o_out_valid, m_hold);
            check("o_out_data",  o_out_data,  m_data);
            check("o_out_err",   o_out_err,   m_hold && !m_err_even);
            check("o_err_count", o_err_count, m_cnt_o);
        end
        inc_e = 1'b0;
        inc_o = 1'b0;
        if (rs) begin
            m_hold = 1'b0; m_bits = 0; m_acc = '0; m_data = '0;
            m_err_even = 1'b0; m_cnt_e = 0; m_cnt_o = 0;
        end else begin
            if (v && !m_hold) begin
                if (m_bits < DW) begin
                    m_acc[m_bits[1:0]] = b;
                    m_bits++;
                end else begin
                    m_data     = m_acc;
                    m_err_even = (($countones(m_acc) + int'(b)) % 2) == 1;
                    inc_e      = m_err_even;
                    inc_o      = !m_err_even;
                    m_hold     = 1'b1;
                    m_bits     = 0;
                end
            end else if (m_hold && r) begin
                m_hold = 1'b0;
            end
            if (c) begin
                m_cnt_e = 0;
                m_cnt_o = 0;
            end else begin
                if (inc_e && m_cnt_e < 3)   m_cnt_e++;
                if (inc_o && m_cnt_o < 255) m_cnt_o++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic clr_on_parity);
        for (int i = 0; i < DW; i++) cycle(1'b1, d[i], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, p, 1'b0, clr_on_parity, 1'b0);
    endtask

    task automatic take();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_in_ready", e_in_ready, 1);
        check("rst_out_valid", e_out_valid, 0);
        check("rst_out_data", e_out_data, 0);
        check("rst_err_count", e_err_count, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b1101, 1'b1, 1'b0);
        check("clean_valid", e_out_valid, 1);
        check("clean_data", e_out_data, 4'b1101);
        check("clean_err", e_out_err, 0);
        check("clean_count", e_err_count, 0);
        check("clean_odd_err", o_out_err, 1);
        take();
        check("collect_valid", e_out_valid, 0);
        check("collect_err", e_out_err, 0);
        check("collect_data_kept", e_out_data, 4'b1101);

        send_frame(4'b1101, 1'b0, 1'b0);
        check("bad_err", e_out_err, 1);
        check("bad_count", e_err_count, 1);
        check("odd_mode_err", o_out_err, 0);
        take();

        send_frame(4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            check("bp_in_ready", e_in_ready, 0);
            check("bp_data", e_out_data, 4'b0110);
            check("bp_err", e_out_err, 1);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(4'b0011, 1'b0, 1'b0);
        check("after_bp_data", e_out_data, 4'b0011);
        check("after_bp_err", e_out_err, 0);
        take();

        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cleared", e_err_count, 0);
        for (int i = 0; i < 4; i++) begin
            send_frame(4'b1101, 1'b0, 1'b0);
            take();
        end
        check("saturated", e_err_count, 3);
        send_frame(4'b1101, 1'b0, 1'b1);
        check("clr_wins", e_err_count, 0);
        check("clr_frame_err", e_out_err, 1);
        take();

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_in_ready", e_in_ready, 1);
        send_frame(4'b0110, 1'b0, 1'b0);
        check("midrst_data", e_out_data, 4'b0110);
        check("midrst_err", e_out_err, 0);
        take();

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
